// File: rtl/regfile_pkg.sv
// Shared types and core-configuration constants for the multi-port register file.
package regfile_pkg;

    // Default core configuration: register width and register count.
    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    // Clear-sequencer states: sweeping the array to zero, or open for traffic.
    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

endpackage : regfile_pkg

// File: rtl/regfile_clr_seq.sv
// Post-reset clear sequencer: walks every entry once, writing zero, then
// raises ready. The current state is exported for observation.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH  = NREGS,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready,
    output rf_state_t         state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rf_state_t         state_q;
    rf_state_t         state_d;
    logic [ADDR_W-1:0] clr_ptr_q;
    logic [ADDR_W-1:0] clr_ptr_d;

    // State and sweep-pointer registers; reset restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RF_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Next-state logic: one entry cleared per edge; the edge that clears the
    // last entry moves to READY, so ready rises exactly DEPTH edges after reset.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clr_we    = 1'b0;
        case (state_q)
            RF_CLEAR: begin
                // No sweep write on a reset edge; only the sequencer restarts.
                clr_we    = !rst;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d = RF_READY;
                end
            end
            RF_READY: begin
                state_d = RF_READY;
            end
            default: begin
                state_d   = RF_CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // ready is a pure decode of the registered state, so it changes only on edges.
    assign ready    = (state_q == RF_READY);
    assign clr_addr = clr_ptr_q;
    assign state    = state_q;

endmodule : regfile_clr_seq

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD combinational
// read ports with optional same-cycle write bypass and hardwired-zero entry 0.
//
// Handshake: there is no per-transaction valid/ready. ready is a level that
// stays low from reset until the clear sweep completes. While ready is low,
// we0/we1 are ignored and every rdata lane reads zero; while ready is high a
// write presented with its enable is committed at the next posedge and reads
// are valid in the same cycle the address is presented.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int DEPTH    = NREGS,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     ready
);

    localparam bit HAS_ZERO   = (ZERO_REG != 0);
    localparam bit HAS_BYPASS = (BYPASS != 0);

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    rf_state_t         rf_state;
    logic              accepting;
    logic              wr0_en;
    logic              wr1_en;
    logic              wr0_cmt;

    // Storage; its only initialisation is the clear sweep.
    logic [DATA_W-1:0] mem [DEPTH];

    regfile_clr_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready),
        .state    (rf_state)
    );

    // Write qualification: only in READY, and never into a hardwired-zero entry 0.
    always_comb begin
        accepting = (rf_state == RF_READY);
        wr1_en    = we1 && accepting && !(HAS_ZERO && (waddr1 == '0));
        wr0_en    = we0 && accepting && !(HAS_ZERO && (waddr0 == '0));
        // Port 1 owns a shared address; port 0's data is dropped.
        wr0_cmt   = wr0_en && !(wr1_en && (waddr1 == waddr0));
    end

    // Array update: the clear sweep has the array to itself; otherwise both
    // write ports may commit on the same edge to different entries.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (wr0_cmt) begin
                mem[waddr0] <= wdata0;
            end
            if (wr1_en) begin
                mem[waddr1] <= wdata1;
            end
        end
    end

    // One combinational read lane per port.
    genvar gi;
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = raddr[gi*ADDR_W +: ADDR_W];

        // Read mux: bypass (port 1 first) over array, then zero-entry and clear masking.
        always_comb begin
            rd = mem[ra];
            if (HAS_BYPASS && wr1_en && (waddr1 == ra)) begin
                rd = wdata1;
            end else if (HAS_BYPASS && wr0_en && (waddr0 == ra)) begin
                rd = wdata0;
            end
            if (HAS_ZERO && (ra == '0)) begin
                rd = '0;
            end
            if (!ready) begin
                rd = '0;
            end
        end

        assign rdata[gi*DATA_W +: DATA_W] = rd;
    end

endmodule : regfile_mp
